// File: rtl/tpu_tile_scheduler.sv
// ============================================================================
// Module   : tpu_tile_scheduler
// Brief    : Walks an MxKxN matmul as TILE-sized tiles and drives the engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tpu_tile_scheduler #(
    parameter int ADDR_WIDTH = 12,
    parameter int TILE       = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] m_i,
    input  logic [ADDR_WIDTH-1:0] k_i,
    input  logic [ADDR_WIDTH-1:0] n_i,
    input  logic [ADDR_WIDTH-1:0] base_addra_i,
    input  logic [ADDR_WIDTH-1:0] base_addrb_i,
    input  logic [ADDR_WIDTH-1:0] base_addrp_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  eng_start_o,
    input  logic                  eng_valid_i,
    output logic [ADDR_WIDTH-1:0] eng_m_o,
    output logic [ADDR_WIDTH-1:0] eng_k_o,
    output logic [ADDR_WIDTH-1:0] eng_n_o,
    output logic [ADDR_WIDTH-1:0] eng_addra_o,
    output logic [ADDR_WIDTH-1:0] eng_addrb_o,
    output logic [ADDR_WIDTH-1:0] eng_addrp_o,
    output logic [ADDR_WIDTH-1:0] eng_stra_o,
    output logic [ADDR_WIDTH-1:0] eng_strp_o,
    output logic                  eng_acc_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_ADVANCE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] C_TILE   = ADDR_WIDTH'(TILE);
    localparam logic [ADDR_WIDTH:0]   C_TILE_X = (ADDR_WIDTH+1)'(TILE);
    localparam logic [ADDR_WIDTH:0]   C_RND_X  = (ADDR_WIDTH+1)'(TILE - 1);

    state_t r_state, w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_m, r_k, r_n;
    logic [ADDR_WIDTH-1:0] r_base_a, r_base_b, r_base_p;
    logic [ADDR_WIDTH-1:0] r_m_rem, r_k_rem, r_n_rem;
    logic [ADDR_WIDTH-1:0] r_wa, r_wb, r_wa_t, r_wb_t;
    logic [ADDR_WIDTH-1:0] r_a_row, r_b_col, r_p_row;
    logic [ADDR_WIDTH-1:0] r_addra, r_addrb, r_addrp;
    logic                  r_acc;
    logic                  r_err;

    logic [ADDR_WIDTH:0]   w_k_rnd, w_n_rnd;
    logic [ADDR_WIDTH-1:0] w_wa, w_wb, w_wa_t, w_wb_t;
    logic                  w_zero;
    logic                  w_last;
    logic                  w_k_wrap, w_n_wrap;

    // Words per row; TILE is a constant so these reduce to fixed logic.
    assign w_k_rnd = {1'b0, r_k} + C_RND_X;
    assign w_n_rnd = {1'b0, r_n} + C_RND_X;
    assign w_wa    = ADDR_WIDTH'(w_k_rnd / C_TILE_X);
    assign w_wb    = ADDR_WIDTH'(w_n_rnd / C_TILE_X);
    assign w_wa_t  = w_wa * C_TILE;
    assign w_wb_t  = w_wb * C_TILE;
    assign w_zero  = (r_m == '0) || (r_k == '0) || (r_n == '0);

    // Remaining extent along each axis doubles as the tile index.
    assign w_k_wrap = (r_k_rem <= C_TILE);
    assign w_n_wrap = (r_n_rem <= C_TILE);
    assign w_last   = w_k_wrap && w_n_wrap && (r_m_rem <= C_TILE);

    assign eng_m_o     = (r_m_rem > C_TILE) ? C_TILE : r_m_rem;
    assign eng_k_o     = (r_k_rem > C_TILE) ? C_TILE : r_k_rem;
    assign eng_n_o     = (r_n_rem > C_TILE) ? C_TILE : r_n_rem;
    assign eng_addra_o = r_addra;
    assign eng_addrb_o = r_addrb;
    assign eng_addrp_o = r_addrp;
    assign eng_stra_o  = r_wa;
    assign eng_strp_o  = r_wb;
    assign eng_acc_o   = r_acc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        err_o       = 1'b0;
        eng_start_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                w_state_nxt = w_zero ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                eng_start_o = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (eng_valid_i) begin
                    w_state_nxt = w_last ? S_DONE : S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                w_state_nxt = S_ISSUE;
            end
            S_DONE: begin
                done_o      = 1'b1;
                err_o       = r_err;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_m      <= '0;
            r_k      <= '0;
            r_n      <= '0;
            r_base_a <= '0;
            r_base_b <= '0;
            r_base_p <= '0;
            r_m_rem  <= '0;
            r_k_rem  <= '0;
            r_n_rem  <= '0;
            r_wa     <= '0;
            r_wb     <= '0;
            r_wa_t   <= '0;
            r_wb_t   <= '0;
            r_a_row  <= '0;
            r_b_col  <= '0;
            r_p_row  <= '0;
            r_addra  <= '0;
            r_addrb  <= '0;
            r_addrp  <= '0;
            r_acc    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_m      <= m_i;
                        r_k      <= k_i;
                        r_n      <= n_i;
                        r_m_rem  <= m_i;
                        r_k_rem  <= k_i;
                        r_n_rem  <= n_i;
                        r_base_a <= base_addra_i;
                        r_base_b <= base_addrb_i;
                        r_base_p <= base_addrp_i;
                    end
                end
                S_CHECK: begin
                    r_wa    <= w_wa;
                    r_wb    <= w_wb;
                    r_wa_t  <= w_wa_t;
                    r_wb_t  <= w_wb_t;
                    r_a_row <= r_base_a;
                    r_addra <= r_base_a;
                    r_b_col <= r_base_b;
                    r_addrb <= r_base_b;
                    r_p_row <= r_base_p;
                    r_addrp <= r_base_p;
                    r_acc   <= 1'b0;
                    r_err   <= w_zero;
                end
                S_ADVANCE: begin
                    if (!w_k_wrap) begin
                        r_k_rem <= r_k_rem - C_TILE;
                        r_addra <= r_addra + 1'b1;
                        r_addrb <= r_addrb + r_wb_t;
                        r_acc   <= 1'b1;
                    end else begin
                        r_k_rem <= r_k;
                        r_acc   <= 1'b0;
                        if (!w_n_wrap) begin
                            r_n_rem <= r_n_rem - C_TILE;
                            r_addra <= r_a_row;
                            r_b_col <= r_b_col + 1'b1;
                            r_addrb <= r_b_col + 1'b1;
                            r_addrp <= r_addrp + 1'b1;
                        end else begin
                            r_n_rem <= r_n;
                            r_m_rem <= r_m_rem - C_TILE;
                            r_a_row <= r_a_row + r_wa_t;
                            r_addra <= r_a_row + r_wa_t;
                            r_b_col <= r_base_b;
                            r_addrb <= r_base_b;
                            r_p_row <= r_p_row + r_wb_t;
                            r_addrp <= r_p_row + r_wb_t;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/tpu_tile_scheduler.md
# tpu_tile_scheduler

Sequences the 10x10 TPU tile engine over an arbitrary M×K×N matrix multiply held in the global buffers A, B and P. It splits the problem into tiles, computes each tile's base addresses, row strides and ragged dimensions, and issues one engine start per tile. It accumulates partial products across K-tiles and reports completion to the host controller. It sits between the host/config registers and the engine's `start_i`/`valid_o` handshake and does not touch buffer data.

## Interface

Parameters:
- `ADDR_WIDTH`, 12: global-buffer word address width; also the dimension width.
- `TILE`, 10: tile edge, equal to the number of 16-bit elements per 160-bit word.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: job request; sampled only in IDLE.
- `m_i`, `k_i`, `n_i` in ADDR_WIDTH each: matrix dimensions; sampled on an accepted start.
- `base_addra_i`, `base_addrb_i`, `base_addrp_i` in ADDR_WIDTH each: buffer base word addresses; sampled on an accepted start.
- `busy_o` out 1: a job is in progress.
- `done_o` out 1: one-cycle pulse at job end.
- `err_o` out 1: one-cycle pulse coincident with `done_o` when the job was rejected.
- `eng_start_o` out 1: one-cycle tile start pulse to the engine.
- `eng_valid_i` in 1: engine tile-complete pulse.
- `eng_m_o`, `eng_k_o`, `eng_n_o` out ADDR_WIDTH each: tile dimensions, each 1..TILE.
- `eng_addra_o`, `eng_addrb_o`, `eng_addrp_o` out ADDR_WIDTH each: tile base word addresses.
- `eng_stra_o` out ADDR_WIDTH: A row stride in words.
- `eng_strp_o` out ADDR_WIDTH: B and P row stride in words.
- `eng_acc_o` out 1: 0 = overwrite P tile, 1 = accumulate into P tile.

## Operation

- Layout is row-major, TILE elements per word.
  - `wa = ceil(k/TILE)` words per A row.
  - `wb = ceil(n/TILE)` words per B row and per P row.
- Tile indices: `mt` in 0..ceil(m/TILE)-1, `nt` in 0..wb-1, `kt` in 0..wa-1.
- Loop order: `mt` outermost, then `nt`, then `kt` innermost.
- Per-tile values:
  - A base = `base_a + mt*TILE*wa + kt`
  - B base = `base_b + kt*TILE*wb + nt`
  - P base = `base_p + mt*TILE*wb + nt`
  - `eng_stra_o = wa`, `eng_strp_o = wb`
  - `eng_acc_o = (kt != 0)`
- Ragged dimensions:
  - `eng_m_o = min(TILE, m - mt*TILE)`
  - `eng_k_o = min(TILE, k - kt*TILE)`
  - `eng_n_o = min(TILE, n - nt*TILE)`
- Address generation is incremental: running row-base registers are advanced by adders only, with no multipliers. All address sums wrap modulo 2^ADDR_WIDTH.
- FSM:
  - IDLE: on `start_i`, latch all inputs and go to CHECK.
  - CHECK: compute `wa` and `wb` and clear the indices. If `m`, `k` or `n` is 0, go to DONE with the error flag set; otherwise go to ISSUE.
  - ISSUE: assert `eng_start_o`, go to WAIT.
  - WAIT: hold until `eng_valid_i`. If that was the last tile, go to DONE; otherwise go to ADVANCE.
  - ADVANCE: step `kt`; on `kt` wrap step `nt`; on `nt` wrap step `mt`. Go to ISSUE.
  - DONE: pulse `done_o` (and `err_o` if the flag is set), go to IDLE.
- `busy_o` is high in every state except IDLE.

## Timing

- Reset values: `busy_o`, `done_o`, `err_o`, `eng_start_o`, `eng_acc_o` are 0; all `eng_*` vectors are 0; state is IDLE.
- Reset asserted in any state returns to IDLE next cycle, and no further `eng_start_o` is issued. The engine is reset by the same `rst_i`.
- `start_i` at edge T is accepted; `busy_o` is high from T+1.
- The first `eng_start_o` is high during cycle T+2.
- All `eng_*` configuration outputs are valid in the `eng_start_o` cycle and stay stable until the cycle after `eng_valid_i` is sampled.
- `eng_valid_i` at edge V:
  - non-last tile: next `eng_start_o` at V+2;
  - last tile: `done_o` high during V+1, `busy_o` low from V+2.
- `eng_valid_i` outside WAIT is ignored.
- `start_i` while `busy_o` is ignored, including in the DONE cycle.
- Rejected job: `done_o` and `err_o` are high during T+2, and `eng_start_o` is never asserted.

## Test plan

- 10×10×10, bases 0x000/0x100/0x200:
  - `eng_start_o` at T+2 with m/k/n = 10, A/B/P = 0x000/0x100/0x200, strides 1/1, acc = 0.
  - `eng_valid_i` at V → `done_o` at V+1.
- 20×20×20, same bases: 8 tiles, wa = wb = 2.
  - Tile 2 (mt0, nt0, kt1): A 0x001, B 0x114, P 0x200, acc = 1.
  - Tile 8 (mt1, nt1, kt1): A 0x015, B 0x115, P 0x215.
- 15×7×23: 6 tiles, wa = 1, wb = 3.
  - `eng_m_o` = 10,10,10,5,5,5.
  - `eng_n_o` = 10,10,3 repeated.
  - `eng_k_o` = 7 throughout; acc always 0.
- `k_i = 0`: `done_o` and `err_o` together at T+2, zero `eng_start_o` pulses, `busy_o` low at T+3.
- Interference:
  - `start_i` pulsed during WAIT → no effect on the tile sequence.
  - Stray `eng_valid_i` in IDLE → no effect.
- `rst_i` during WAIT of tile 3 of a 20³ job:
  - all outputs return to 0 next cycle;
  - a new start restarts at tile (0,0,0) with acc = 0.
